uart_rx_core: RTL and testbench

- UART receive front end: integrated oversampling baud-tick generator plus 8N1 frame sampler.
- Converts the asynchronous serial line rx_in into parallel bytes, each with a one-cycle valid strobe.
- Sits directly behind the board RX pin and feeds the pattern-matching logic.
- Single clock domain, sys_clk, 25 MHz nominal.

---
 rtl/uart_rx_core.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: free-running oversample tick generator, 2-flop synchronizer, frame sampler.
// Optional frame_err output enabled by defining UART_RX_FRAME_ERR_EN.
`timescale 1ns / 1ps
module uart_rx_core #(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 8
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int unsigned TICK_DIV =
        (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]  OS_MAX  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic              baud_tick;
    logic              rx_meta_q, rx_s;
    logic [OS_W-1:0]   tcnt_q, tcnt_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
`ifdef UART_RX_FRAME_ERR_EN
    logic              ferr_q, ferr_d;
`endif

    // Tick phase is never realigned to rx edges.
    assign baud_tick = (div_q == DIV_MAX);

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= baud_tick ? '0 : div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s      <= rx_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_d  = 1'b0;
`endif
        if (baud_tick) begin
            case (state_q)
                StIdle: begin
                    if (!rx_s) begin
                        state_d = StStart;
                        tcnt_d  = '0;
                    end
                end
                StStart: begin
                    if (tcnt_q == OS_HALF) begin
                        tcnt_d  = '0;
                        bcnt_d  = '0;
                        state_d = rx_s ? StIdle : StData;
                    end else begin
                        tcnt_d = tcnt_q + OS_W'(1);
                    end
                end
                StData: begin
                    if (tcnt_q == OS_MAX) begin
                        tcnt_d  = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bcnt_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bcnt_d = bcnt_q + 3'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + OS_W'(1);
                    end
                end
                StStop: begin
                    if (tcnt_q == OS_MAX) begin
                        tcnt_d = '0;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = StIdle;
                        end else begin
`ifdef UART_RX_FRAME_ERR_EN
                            ferr_d  = 1'b1;
`endif
                            state_d = StWaitIdle;
                        end
                    end else begin
                        tcnt_d = tcnt_q + OS_W'(1);
                    end
                end
                StWaitIdle: begin
                    // A stuck-low line must not be read as a stream of 0x00 bytes.
                    if (rx_s) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;

`ifdef UART_RX_FRAME_ERR_EN
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            ferr_q <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
        end
    end

    assign frame_err = ferr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: stimulus pushes expected bytes, a monitor pops on data_valid.
`timescale 1ns / 1ps
module tb_uart_rx_core;

    localparam time BIT_NS = 8680;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       rx_in   = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
    int         ferr_cnt = 0;
`endif

    int         total = 0;
    int         bad   = 0;
    int         pulse_cnt = 0;
    logic [7:0] sb[$];
    time        last_valid_t = 0;
    time        last_start_t = 0;

    uart_rx_core dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .data_out   (data_out),
`ifdef UART_RX_FRAME_ERR_EN
        .frame_err  (frame_err),
`endif
        .data_valid (data_valid)
    );

    always #20 sys_clk = ~sys_clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every strobe must match the oldest outstanding expected byte.
    always @(negedge sys_clk) begin
        if (reset && data_valid) begin
            last_valid_t = $time;
            pulse_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got=%h expected=none at %0t", data_out, $time);
            end else begin
                check("rx_byte", {24'h0, data_out}, {24'h0, sb.pop_front()});
            end
        end
`ifdef UART_RX_FRAME_ERR_EN
        if (reset && frame_err) ferr_cnt++;
`endif
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) sb.push_back(b);
        last_start_t = $time;
        rx_in = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            #(BIT_NS);
        end
        rx_in = stop_bit;
        #(BIT_NS);
    endtask

    initial begin
        time lat;
        #7;
        #93;
        check("reset_data_out", {24'h0, data_out}, 32'h0);
        check("reset_data_valid", {31'h0, data_valid}, 32'h0);
        reset = 1'b1;
        #5000;

        // First frame and its latency from the start edge.
        send_byte(8'hD6, 1'b1);
        #(BIT_NS);
        lat = last_valid_t - last_start_t;
        check("latency_window",
              {31'h0, (last_valid_t > last_start_t) && (lat >= 81500) && (lat <= 84500)}, 32'h1);

        #20000;
        send_byte(8'h35, 1'b1);
        #30000;
        check("hold_after_35", {24'h0, data_out}, 32'h35);

        // Back-to-back, no idle between stop and next start.
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'hA5, 1'b1);
        #20000;

        // Short low glitch must be rejected at the start-bit centre.
        rx_in = 1'b0;
        #2000;
        rx_in = 1'b1;
        #20000;
        send_byte(8'h5A, 1'b1);
        #20000;

        // Framing error: stop bit low, then line low 3 more bit times.
        send_byte(8'h3C, 1'b0);
        #(3 * BIT_NS);
        rx_in = 1'b1;
        #20000;
        check("hold_after_ferr", {24'h0, data_out}, 32'h5A);
        send_byte(8'h81, 1'b1);
        #20000;

        // Reset in the middle of bit 4 of a frame.
        rx_in = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx_in = i[0];
            #(BIT_NS);
        end
        rx_in = 1'b1;
        #(BIT_NS / 2);
        reset = 1'b0;
        #1;
        check("midreset_data_out", {24'h0, data_out}, 32'h0);
        check("midreset_data_valid", {31'h0, data_valid}, 32'h0);
        #200;
        reset = 1'b1;
        #20000;
        send_byte(8'hC3, 1'b1);
        #20000;

        check("sb_drained", sb.size(), 32'h0);
        check("pulse_count", pulse_cnt, 32'd8);
        check("final_data_out", {24'h0, data_out}, 32'hC3);
`ifdef UART_RX_FRAME_ERR_EN
        check("frame_err_count", ferr_cnt, 32'd1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
